// File: rtl/pwm_update_sequencer.sv
// pwm_update_sequencer
//
// Takes one PWM update command (three duty values, a period and a deadband)
// and turns it into a fixed burst of ten Avalon-MM writes to a modulator
// slave. The burst order is low0, high0, low1, high1, low2, high2, period,
// latch-at-zero, latch-at-max and finally a commit write to address 0xF.
//
// Optional feature macro: PWM_SEQ_DEADBAND_EN
//   defined   : low_i = d_i - deadband (floor 0), high_i = d_i + deadband (ceiling 0xFFFF)
//   undefined : deadband is ignored, low_i = high_i = d_i
//
// Ports
//   clk             : sole clock, rising edge
//   reset           : asynchronous, active-high reset
//   cmd_valid       : command present
//   cmd_ready       : sequencer idle; command taken when cmd_valid & cmd_ready
//   cmd_duty0..2    : per-phase duty compare values
//   cmd_period      : modulator max counter value
//   deadband        : deadtime half-width in counter ticks
//   MMM_addr        : Avalon-MM address to modulator
//   MMM_write       : write strobe, high throughout the burst
//   MMM_writedata   : write data, upper 16 bits always zero
//   MMM_waitrequest : slave stall
//   busy            : high whenever not idle
//   done            : one-cycle pulse after the commit write is accepted
module pwm_update_sequencer #(
  parameter logic [15:0] UPDATE_ON0   = 16'd1,
  parameter logic [15:0] UPDATE_ONMAX = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_duty0,
  input  logic [15:0] cmd_duty1,
  input  logic [15:0] cmd_duty2,
  input  logic [15:0] cmd_period,
  input  logic [15:0] deadband,
  output logic [3:0]  MMM_addr,
  output logic        MMM_write,
  output logic [31:0] MMM_writedata,
  input  logic        MMM_waitrequest,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StCalc, StWrite, StDone} state_e;

  localparam logic [3:0] LastBeat = 4'd9;

  state_e           state_q;
  logic [2:0][15:0] duty_q;
  logic [15:0]      period_q;
  logic [2:0][15:0] lo_q;
  logic [2:0][15:0] hi_q;
  logic [3:0]       beat_q;
  logic [3:0]       addr_q;
  logic [15:0]      wdata_q;
  logic             write_q;
  logic             done_q;

  logic [2:0][15:0] d_c;
  logic [2:0][15:0] lo_c;
  logic [2:0][15:0] hi_c;
  logic [3:0]       beat_nx;
  logic [3:0]       nx_addr;
  logic [15:0]      nx_data;

`ifdef PWM_SEQ_DEADBAND_EN
  logic [15:0]      deadband_q;
  logic [2:0][16:0] diff_c;
  logic [2:0][16:0] sum_c;
`else
  logic             unused_deadband;
  assign unused_deadband = ^deadband;
`endif

  // Clamp duty to period, then widen by the deadband with saturation.
  always_comb begin
    d_c  = '0;
    lo_c = '0;
    hi_c = '0;
`ifdef PWM_SEQ_DEADBAND_EN
    diff_c = '0;
    sum_c  = '0;
`endif
    for (int i = 0; i < 3; i++) begin
      d_c[i] = (duty_q[i] > period_q) ? period_q : duty_q[i];
`ifdef PWM_SEQ_DEADBAND_EN
      // 17-bit intermediates: bit 16 flags borrow / carry out.
      diff_c[i] = {1'b0, d_c[i]} - {1'b0, deadband_q};
      sum_c[i]  = {1'b0, d_c[i]} + {1'b0, deadband_q};
      lo_c[i]   = diff_c[i][16] ? 16'h0000 : diff_c[i][15:0];
      hi_c[i]   = sum_c[i][16]  ? 16'hFFFF : sum_c[i][15:0];
`else
      lo_c[i] = d_c[i];
      hi_c[i] = d_c[i];
`endif
    end
  end

  // Address/data of the beat following the current one. Beat 0 is loaded
  // straight from the CALC results, so only beats 1..9 are decoded here.
  always_comb begin
    beat_nx = beat_q + 4'd1;
    nx_addr = 4'h0;
    nx_data = lo_q[0];
    case (beat_nx)
      4'd1: begin nx_addr = 4'h1; nx_data = hi_q[0];     end
      4'd2: begin nx_addr = 4'h2; nx_data = lo_q[1];     end
      4'd3: begin nx_addr = 4'h3; nx_data = hi_q[1];     end
      4'd4: begin nx_addr = 4'h4; nx_data = lo_q[2];     end
      4'd5: begin nx_addr = 4'h5; nx_data = hi_q[2];     end
      4'd6: begin nx_addr = 4'h8; nx_data = period_q;    end
      4'd7: begin nx_addr = 4'h9; nx_data = UPDATE_ON0;  end
      4'd8: begin nx_addr = 4'hA; nx_data = UPDATE_ONMAX; end
      4'd9: begin nx_addr = 4'hF; nx_data = 16'd1;       end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      duty_q     <= '0;
      period_q   <= '0;
`ifdef PWM_SEQ_DEADBAND_EN
      deadband_q <= '0;
`endif
      lo_q       <= '0;
      hi_q       <= '0;
      beat_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            duty_q     <= {cmd_duty2, cmd_duty1, cmd_duty0};
            period_q   <= cmd_period;
`ifdef PWM_SEQ_DEADBAND_EN
            deadband_q <= deadband;
`endif
            state_q    <= StCalc;
          end
        end
        StCalc: begin
          lo_q    <= lo_c;
          hi_q    <= hi_c;
          beat_q  <= '0;
          addr_q  <= 4'h0;
          wdata_q <= lo_c[0];
          write_q <= 1'b1;
          state_q <= StWrite;
        end
        StWrite: begin
          // Outputs only move on an accepted beat, so they hold during a stall.
          if (!MMM_waitrequest) begin
            if (beat_q == LastBeat) begin
              write_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              beat_q  <= beat_nx;
              addr_q  <= nx_addr;
              wdata_q <= nx_data;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign MMM_write     = write_q;
  assign MMM_addr      = addr_q;
  assign MMM_writedata = {16'h0000, wdata_q};

endmodule

// File: tb/tb_pwm_update_sequencer.sv
module tb_pwm_update_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_duty0 = '0;
  logic [15:0] cmd_duty1 = '0;
  logic [15:0] cmd_duty2 = '0;
  logic [15:0] cmd_period = '0;
  logic [15:0] deadband = '0;
  logic [3:0]  MMM_addr;
  logic        MMM_write;
  logic [31:0] MMM_writedata;
  logic        MMM_waitrequest = 1'b0;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [3:0]  log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = -1;

  logic [3:0] addr_tab[10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hF};

  pwm_update_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_duty0       (cmd_duty0),
    .cmd_duty1       (cmd_duty1),
    .cmd_duty2       (cmd_duty2),
    .cmd_period      (cmd_period),
    .deadband        (deadband),
    .MMM_addr        (MMM_addr),
    .MMM_write       (MMM_write),
    .MMM_writedata   (MMM_writedata),
    .MMM_waitrequest (MMM_waitrequest),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (MMM_write && !MMM_waitrequest) begin
      log_addr.push_back(MMM_addr);
      log_data.push_back(MMM_writedata);
      log_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  // Called just after a rising edge; returns the acceptance cycle n and
  // leaves the bench just after the edge that enters CALC, inputs scrambled.
  task automatic issue_cmd(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                           input logic [15:0] per, input logic [15:0] db, output int n);
    cmd_duty0  = d0;
    cmd_duty1  = d1;
    cmd_duty2  = d2;
    cmd_period = per;
    deadband   = db;
    cmd_valid  = 1'b1;
    @(negedge clk);
    n = cyc;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_duty0  = 16'hA5A5;
    cmd_duty1  = 16'h5A5A;
    cmd_duty2  = 16'h1357;
    cmd_period = 16'h2468;
    deadband   = 16'h0777;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && done_cnt == 0; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (MMM_write !== 1'b0) begin fails++; $display("FAIL reset_write: got %b want 0", MMM_write); end
    tests++; if (MMM_addr !== 4'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", MMM_addr); end
    tests++; if (MMM_writedata !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", MMM_writedata); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Nominal burst; cmd_valid is also held high with junk while busy.
  task automatic test_basic();
    int n;
    logic [15:0] exp_d[10];
`ifdef PWM_SEQ_DEADBAND_EN
    exp_d = '{16'h0FF0, 16'h1010, 16'h1FF0, 16'h2010, 16'h2FF0, 16'h3010, 16'h4000, 16'h1, 16'h0, 16'h1};
`else
    exp_d = '{16'h1000, 16'h1000, 16'h2000, 16'h2000, 16'h3000, 16'h3000, 16'h4000, 16'h1, 16'h0, 16'h1};
`endif
    clear_log();
    issue_cmd(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h0010, n);
    cmd_valid = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      fails++; $display("FAIL basic_busy: busy=%b ready=%b want 1/0", busy, cmd_ready);
    end
    cmd_valid = 1'b0;
    wait_done();
    tests++; if (done_cnt !== 1 || done_cyc !== n + 12) begin
      fails++; $display("FAIL basic_done: count=%0d cycle=%0d want 1/%0d", done_cnt, done_cyc, n + 12);
    end
    tests++; if (cmd_ready !== 1'b1 || cyc !== n + 13) begin
      fails++; $display("FAIL basic_ready_after: ready=%b cycle=%0d want 1/%0d", cmd_ready, cyc, n + 13);
    end
    tests++; if (log_addr.size() !== 10) begin
      fails++; $display("FAIL basic_count: %0d beats want 10", log_addr.size());
    end
    for (int i = 0; i < 10; i++) begin
      if (i < log_addr.size()) begin
        tests++;
        if (log_addr[i] !== addr_tab[i] || log_data[i] !== {16'h0, exp_d[i]} ||
            log_cyc[i] !== n + 2 + i) begin
          fails++;
          $display("FAIL basic_beat%0d: addr=%h data=%h cyc=%0d want %h/%h/%0d", i, log_addr[i],
                   log_data[i], log_cyc[i], addr_tab[i], exp_d[i], n + 2 + i);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int n;
    logic [15:0] exp_d[10];
`ifdef PWM_SEQ_DEADBAND_EN
    exp_d = '{16'h0000, 16'h0015, 16'hFFE8, 16'hFFFF, 16'h00F0, 16'h0110, 16'hFFFF, 16'h1, 16'h0, 16'h1};
`else
    exp_d = '{16'h0005, 16'h0005, 16'hFFF8, 16'hFFF8, 16'h0100, 16'h0100, 16'hFFFF, 16'h1, 16'h0, 16'h1};
`endif
    clear_log();
    issue_cmd(16'h0005, 16'hFFF8, 16'h0100, 16'hFFFF, 16'h0010, n);
    wait_done();
    tests++; if (done_cnt !== 1 || log_addr.size() !== 10) begin
      fails++; $display("FAIL sat_count: done=%0d beats=%0d want 1/10", done_cnt, log_addr.size());
    end
    for (int i = 0; i < 10; i++) begin
      if (i < log_addr.size()) begin
        tests++;
        if (log_addr[i] !== addr_tab[i] || log_data[i] !== {16'h0, exp_d[i]}) begin
          fails++;
          $display("FAIL sat_beat%0d: addr=%h data=%h want %h/%h", i, log_addr[i], log_data[i],
                   addr_tab[i], exp_d[i]);
        end
      end
    end
  endtask

  // Duty above period clamps; then period=0 with deadband=0 forces all zero.
  task automatic test_clamp();
    int n;
    logic [15:0] exp_d[10];
`ifdef PWM_SEQ_DEADBAND_EN
    exp_d = '{16'h0000, 16'h0010, 16'h3FF0, 16'h4010, 16'h3FF0, 16'h4010, 16'h4000, 16'h1, 16'h0, 16'h1};
`else
    exp_d = '{16'h0000, 16'h0000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h1, 16'h0, 16'h1};
`endif
    clear_log();
    issue_cmd(16'h0000, 16'h4000, 16'h5000, 16'h4000, 16'h0010, n);
    wait_done();
    tests++; if (log_addr.size() !== 10) begin
      fails++; $display("FAIL clamp_count: %0d beats want 10", log_addr.size());
    end
    for (int i = 0; i < 10; i++) begin
      if (i < log_addr.size()) begin
        tests++;
        if (log_addr[i] !== addr_tab[i] || log_data[i] !== {16'h0, exp_d[i]}) begin
          fails++;
          $display("FAIL clamp_beat%0d: addr=%h data=%h want %h/%h", i, log_addr[i], log_data[i],
                   addr_tab[i], exp_d[i]);
        end
      end
    end
    exp_d = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1, 16'h0, 16'h1};
    clear_log();
    issue_cmd(16'h1234, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, n);
    wait_done();
    tests++; if (log_addr.size() !== 10) begin
      fails++; $display("FAIL zero_count: %0d beats want 10", log_addr.size());
    end
    for (int i = 0; i < 10; i++) begin
      if (i < log_addr.size()) begin
        tests++;
        if (log_addr[i] !== addr_tab[i] || log_data[i] !== {16'h0, exp_d[i]}) begin
          fails++;
          $display("FAIL zero_beat%0d: addr=%h data=%h want %h/%h", i, log_addr[i], log_data[i],
                   addr_tab[i], exp_d[i]);
        end
      end
    end
  endtask

  // Three-cycle stall on the beat to address 0x3.
  task automatic test_waitrequest();
    int n;
    logic [15:0] exp3;
`ifdef PWM_SEQ_DEADBAND_EN
    exp3 = 16'h2010;
`else
    exp3 = 16'h2000;
`endif
    clear_log();
    issue_cmd(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h0010, n);
    for (int i = 0; i < 20 && !(MMM_write && MMM_addr == 4'h3); i++) begin
      @(posedge clk);
      #1;
    end
    tests++; if (cyc !== n + 5) begin
      fails++; $display("FAIL wait_present: addr3 at cycle %0d want %0d", cyc, n + 5);
    end
    MMM_waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      tests++;
      if (MMM_write !== 1'b1 || MMM_addr !== 4'h3 || MMM_writedata !== {16'h0, exp3}) begin
        fails++;
        $display("FAIL wait_stable%0d: write=%b addr=%h data=%h want 1/3/%h", k, MMM_write,
                 MMM_addr, MMM_writedata, exp3);
      end
    end
    MMM_waitrequest = 1'b0;
    wait_done();
    tests++; if (done_cnt !== 1 || done_cyc !== n + 15) begin
      fails++; $display("FAIL wait_done: count=%0d cycle=%0d want 1/%0d", done_cnt, done_cyc, n + 15);
    end
    tests++; if (log_addr.size() !== 10) begin
      fails++; $display("FAIL wait_count: %0d beats want 10", log_addr.size());
    end
    for (int i = 0; i < 10; i++) begin
      if (i < log_addr.size()) begin
        tests++;
        if (log_addr[i] !== addr_tab[i]) begin
          fails++; $display("FAIL wait_order%0d: addr=%h want %h", i, log_addr[i], addr_tab[i]);
        end
      end
    end
    tests++; if (log_addr.size() > 3 && (log_data[3] !== {16'h0, exp3} || log_cyc[3] !== n + 8)) begin
      fails++; $display("FAIL wait_beat3: data=%h cyc=%0d want %h/%0d", log_data[3], log_cyc[3], exp3, n + 8);
    end
  endtask

  // Reset during the beat to 0x5 aborts; the next command starts over.
  task automatic test_reset_abort();
    int n;
    clear_log();
    issue_cmd(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h0010, n);
    for (int i = 0; i < 20 && !(MMM_write && MMM_addr == 4'h5); i++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    tests++; if (MMM_write !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL abort_write: write=%b busy=%b want 0/0", MMM_write, busy);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    tests++; if (done_cnt !== 0) begin
      fails++; $display("FAIL abort_nodone: done count=%0d want 0", done_cnt);
    end
    tests++; if (log_addr.size() !== 5 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL abort_beats: beats=%0d ready=%b want 5/1", log_addr.size(), cmd_ready);
    end
    clear_log();
    issue_cmd(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h0010, n);
    wait_done();
    tests++; if (done_cnt !== 1 || log_addr.size() !== 10) begin
      fails++; $display("FAIL restart_count: done=%0d beats=%0d want 1/10", done_cnt, log_addr.size());
    end
    tests++; if (log_addr.size() > 0 && (log_addr[0] !== 4'h0 || log_cyc[0] !== n + 2)) begin
      fails++; $display("FAIL restart_first: addr=%h cyc=%0d want 0/%0d", log_addr[0], log_cyc[0], n + 2);
    end
  endtask

  // Deadband on duty0 only: both halves equal d when the feature is off.
  task automatic test_deadband_cfg();
    int n;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
`ifdef PWM_SEQ_DEADBAND_EN
    exp_lo = 16'h0FF0;
    exp_hi = 16'h1010;
`else
    exp_lo = 16'h1000;
    exp_hi = 16'h1000;
`endif
    clear_log();
    issue_cmd(16'h1000, 16'h0000, 16'h0000, 16'h8000, 16'h0010, n);
    wait_done();
    tests++; if (log_addr.size() < 2 || log_data[0] !== {16'h0, exp_lo} || log_data[1] !== {16'h0, exp_hi}) begin
      fails++; $display("FAIL cfg_db: data0=%h data1=%h want %h/%h", log_data[0], log_data[1], exp_lo, exp_hi);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_clamp();
    test_waitrequest();
    test_reset_abort();
    test_deadband_cfg();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
